systolic_stream_sequencer: RTL and testbench

//  Handshake-driven sequencer for the 4-PE systolic array (weight / bias / acc enables, drain_sel).

---
 rtl/systolic_stream_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_systolic_stream_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_stream_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : systolic_stream_sequencer
// Description : Handshake-driven sequencer for an N_PE systolic array.
//               It consumes one valid/ready operand stream in three phases:
//               N_PE weights, then N_PE biases, then 2*N_PE-1 data beats.
//               For each accepted beat it raises the matching weight, bias or
//               skewed accumulate strobe in the same cycle. It then drains
//               the N_PE accumulators through a valid/ready result port.
//               Both sides may stall at any time.
// Option      : SEQ_WEIGHT_REUSE_EN - when defined, start_i together with
//               start_reuse_i skips the weight phase. This only takes effect
//               once weights have been loaded since reset.
// Ports       : clk, rst_n      clock, asynchronous active-low reset
//               start_i         begin a job (sampled in IDLE only)
//               start_reuse_i   with start_i: keep the loaded weights
//               in_valid_i/in_ready_o/in_data_i   operand stream
//               pe_data_o       operand to array (= in_data_i)
//               pe_weight_en_o, pe_bias_en_o      one-hot load strobes
//               pe_acc_en_o     skewed accumulate enables
//               drain_sel_o     accumulator select during drain
//               acc_in_i        selected accumulator from array
//               res_valid_o/res_ready_i/res_data_o  result stream
//               busy_o          job in progress
//               done_o          1-cycle pulse after the last result
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_stream_sequencer #(
  parameter int N_PE = 4,
  parameter int DW   = 4,
  parameter int AW   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic                    start_reuse_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [DW-1:0]           in_data_i,
  output logic [DW-1:0]           pe_data_o,
  output logic [N_PE-1:0]         pe_weight_en_o,
  output logic [N_PE-1:0]         pe_bias_en_o,
  output logic [N_PE-1:0]         pe_acc_en_o,
  output logic [$clog2(N_PE)-1:0] drain_sel_o,
  input  logic [AW-1:0]           acc_in_i,
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic [AW-1:0]           res_data_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int CW = $clog2(2*N_PE);
  localparam int SW = $clog2(N_PE);

  localparam logic [CW-1:0] C_LAST_LOAD  = CW'(N_PE-1);
  localparam logic [CW-1:0] C_LAST_COMP  = CW'(2*N_PE-2);
  localparam logic [CW-1:0] C_LAST_DRAIN = CW'(N_PE-1);
  localparam logic [CW-1:0] C_N_PE       = CW'(N_PE);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_W  = 3'd1,
    S_LOAD_B  = 3'd2,
    S_COMPUTE = 3'd3,
    S_DRAIN   = 3'd4
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            in_ready_q;
  logic            res_valid_q;
  logic [SW-1:0]   drain_sel_q;
  logic            busy_q;
  logic            done_q;

  logic            accept;
  logic            reuse_start;

  // in_ready_q is only ever high in the three loading/compute phases, so an
  // accept can only happen there; every strobe below is gated by it.
  assign accept = in_valid_i & in_ready_q;

`ifdef SEQ_WEIGHT_REUSE_EN
  logic wts_loaded_q;

  // Remembers that a full weight set has been loaded since reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wts_loaded_q <= 1'b0;
    end else if (state_q == S_LOAD_W && accept && cnt_q == C_LAST_LOAD) begin
      wts_loaded_q <= 1'b1;
    end
  end

  assign reuse_start = start_reuse_i & wts_loaded_q;
`else
  logic unused_start_reuse;
  assign unused_start_reuse = start_reuse_i;
  assign reuse_start        = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Phase sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      drain_sel_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q    <= reuse_start ? S_LOAD_B : S_LOAD_W;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        S_LOAD_W: begin
          if (accept) begin
            if (cnt_q == C_LAST_LOAD) begin
              state_q <= S_LOAD_B;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_LOAD_B: begin
          if (accept) begin
            if (cnt_q == C_LAST_LOAD) begin
              state_q <= S_COMPUTE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_COMPUTE: begin
          if (accept) begin
            if (cnt_q == C_LAST_COMP) begin
              state_q     <= S_DRAIN;
              cnt_q       <= '0;
              in_ready_q  <= 1'b0;
              res_valid_q <= 1'b1;
              drain_sel_q <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          // res_valid_q is always high here; drain_sel_q only moves on a
          // completed result handshake so it is stable under backpressure.
          if (res_ready_i) begin
            if (cnt_q == C_LAST_DRAIN) begin
              state_q     <= S_IDLE;
              cnt_q       <= '0;
              res_valid_q <= 1'b0;
              drain_sel_q <= '0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              cnt_q       <= cnt_q + 1'b1;
              drain_sel_q <= SW'(cnt_q + 1'b1);
            end
          end
        end
        default: begin
          state_q     <= S_IDLE;
          cnt_q       <= '0;
          in_ready_q  <= 1'b0;
          res_valid_q <= 1'b0;
          drain_sel_q <= '0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Per-PE strobes (combinational on the accepted beat)
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < N_PE; i++) begin : g_pe_strobe
    localparam logic [CW-1:0] C_IDX = CW'(i);
    logic [CW-1:0] rel;

    // PE i accumulates on compute beats i .. i+N_PE-1. The modular
    // difference cnt-i is below N_PE exactly in that window; for cnt < i it
    // wraps to at least 2*N_PE-i, which is >= N_PE+1.
    assign rel = cnt_q - C_IDX;

    assign pe_weight_en_o[i] = accept && (state_q == S_LOAD_W) && (cnt_q == C_IDX);
    assign pe_bias_en_o[i]   = accept && (state_q == S_LOAD_B) && (cnt_q == C_IDX);
    assign pe_acc_en_o[i]    = accept && (state_q == S_COMPUTE) && (rel < C_N_PE);
  end

  assign in_ready_o  = in_ready_q;
  assign pe_data_o   = in_data_i;
  assign drain_sel_o = drain_sel_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_valid_q ? acc_in_i : '0;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_systolic_stream_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_stream_sequencer
// Description : Self-checking bench for systolic_stream_sequencer (N_PE=4).
//               The reference model is a queue of expected strobe patterns,
//               one entry per operand beat, plus a count of pending results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_stream_sequencer;

  localparam int N_PE = 4;
  localparam int DW   = 4;
  localparam int AW   = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic          start_reuse_i = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          res_ready_i = 1'b0;
  logic [DW-1:0] in_data_i = '0;
  logic [AW-1:0] acc_in_i = '0;
  logic          in_ready_o;
  logic [DW-1:0] pe_data_o;
  logic [3:0]    pe_weight_en_o;
  logic [3:0]    pe_bias_en_o;
  logic [3:0]    pe_acc_en_o;
  logic [1:0]    drain_sel_o;
  logic          res_valid_o;
  logic [AW-1:0] res_data_o;
  logic          busy_o;
  logic          done_o;

  always #5 clk = ~clk;

  systolic_stream_sequencer #(.N_PE(N_PE), .DW(DW), .AW(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .start_reuse_i  (start_reuse_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .in_data_i      (in_data_i),
    .pe_data_o      (pe_data_o),
    .pe_weight_en_o (pe_weight_en_o),
    .pe_bias_en_o   (pe_bias_en_o),
    .pe_acc_en_o    (pe_acc_en_o),
    .drain_sel_o    (drain_sel_o),
    .acc_in_i       (acc_in_i),
    .res_valid_o    (res_valid_o),
    .res_ready_i    (res_ready_i),
    .res_data_o     (res_data_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  typedef struct packed {
    logic [3:0] w;
    logic [3:0] b;
    logic [3:0] a;
  } beat_t;

  beat_t in_q[$];
  int    res_left = 0;
  int    res_idx = 0;
  bit    done_exp = 0;
  bit    wts_ok = 0;
  bit    job_skip_w = 0;
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    start_cyc = 0;
  int    last_lat = -1;
  int    done_cnt = 0;
  int    bias_cnt = 0;

  // Skewed accumulate enables for compute beats 0..6 of a 4-PE array.
  function automatic logic [3:0] acc_pattern(input int k);
    case (k)
      0:       return 4'b0001;
      1:       return 4'b0011;
      2:       return 4'b0111;
      3:       return 4'b1111;
      4:       return 4'b1110;
      5:       return 4'b1100;
      default: return 4'b1000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready_o, 0);
    chk({tag, "_res_valid"}, res_valid_o, 0);
    chk({tag, "_weight_en"}, pe_weight_en_o, 0);
    chk({tag, "_bias_en"}, pe_bias_en_o, 0);
    chk({tag, "_acc_en"}, pe_acc_en_o, 0);
    chk({tag, "_drain_sel"}, drain_sel_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
  endtask

  task automatic model_reset();
    in_q.delete();
    res_left = 0;
    res_idx  = 0;
    done_exp = 0;
    wts_ok   = 0;
  endtask

  task automatic load_job();
    bit skip_w;
    skip_w = 0;
`ifdef SEQ_WEIGHT_REUSE_EN
    skip_w = start_reuse_i && wts_ok;
`endif
    job_skip_w = skip_w;
    if (!skip_w)
      for (int k = 0; k < N_PE; k++) in_q.push_back(beat_t'{w: 4'(1 << k), b: 4'd0, a: 4'd0});
    for (int k = 0; k < N_PE; k++) in_q.push_back(beat_t'{w: 4'd0, b: 4'(1 << k), a: 4'd0});
    for (int k = 0; k < 2*N_PE-1; k++) in_q.push_back(beat_t'{w: 4'd0, b: 4'd0, a: acc_pattern(k)});
    res_left  = N_PE;
    res_idx   = 0;
    start_cyc = cyc;
  endtask

  // One clock cycle: compare outputs against the model mid-cycle, then
  // advance the model across the rising edge. Inputs are set beforehand.
  task automatic cycle();
    beat_t e;
    bit    eir, erv, acc;
    #2;
    eir = (in_q.size() != 0);
    erv = !eir && (res_left > 0);
    acc = eir && in_valid_i;
    e   = acc ? in_q[0] : '0;
    chk("in_ready", in_ready_o, eir);
    chk("weight_en", pe_weight_en_o, e.w);
    chk("bias_en", pe_bias_en_o, e.b);
    chk("acc_en", pe_acc_en_o, e.a);
    chk("pe_data", pe_data_o, in_data_i);
    chk("res_valid", res_valid_o, erv);
    chk("drain_sel", drain_sel_o, erv ? res_idx : 0);
    chk("res_data", res_data_o, erv ? acc_in_i : '0);
    chk("busy", busy_o, eir || erv);
    chk("done", done_o, done_exp);
    if (done_o === 1'b1) begin
      done_cnt++;
      last_lat = cyc - start_cyc;
    end
    if (|pe_bias_en_o) bias_cnt++;
    @(posedge clk);
    cyc++;
    done_exp = 0;
    if (!eir && !erv && start_i) load_job();
    if (acc) begin
      if (in_q[0].w == 4'b1000) wts_ok = 1;
      void'(in_q.pop_front());
    end
    if (erv && res_ready_i) begin
      res_idx++;
      if (res_idx == N_PE) begin
        res_left = 0;
        res_idx  = 0;
        done_exp = 1;
      end
    end
    #1;
  endtask

  // mode 0: streaming, 1: in_valid toggles starting low, 2: res_ready low
  // for 3 cycles at drain beat 2, 3: random, 4: start pulsed during biases.
  task automatic run_job(input string tag, input bit reuse, input int mode);
    int guard, hold, stalls;
    bit tog;
    guard = 0; hold = 0; stalls = 0; tog = 0;
    done_cnt = 0; bias_cnt = 0; last_lat = -1;
    start_i = 1; start_reuse_i = reuse; in_valid_i = 0; res_ready_i = 0;
    cycle();
    start_i = 0; start_reuse_i = 0;
    while (done_cnt == 0 && guard < 300) begin
      in_data_i = DW'($urandom);
      acc_in_i  = AW'($urandom);
      case (mode)
        1: begin in_valid_i = tog; tog = !tog; res_ready_i = 1; end
        2: begin
          in_valid_i  = 1;
          res_ready_i = !(in_q.size() == 0 && res_left > 0 && res_idx == 2 && hold < 3);
          if (!res_ready_i) hold++;
        end
        3: begin
          in_valid_i    = 1'($urandom_range(0, 1));
          res_ready_i   = 1'($urandom_range(0, 1));
          start_i       = 1'($urandom_range(0, 1));
          start_reuse_i = 1'($urandom_range(0, 1));
        end
        4: begin
          in_valid_i = 1; res_ready_i = 1;
          start_i    = (in_q.size() != 0) && (in_q[0].b != 0);
        end
        default: begin in_valid_i = 1; res_ready_i = 1; end
      endcase
      if (in_q.size() == 0 && res_left == 0) start_i = 0;
      if (in_q.size() != 0 && !in_valid_i) stalls++;
      if (in_q.size() == 0 && res_left > 0 && !res_ready_i) stalls++;
      cycle();
      guard++;
    end
    start_i = 0; start_reuse_i = 0;
    cycle();
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_bias_strobes"}, bias_cnt, 4);
    chk({tag, "_latency"}, last_lat, (job_skip_w ? 15 : 19) + stalls);
  endtask

  initial begin
    int g;
    // Reset state
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1;
    cycle();

    // T1: asynchronous reset in the middle of the compute phase
    start_i = 1; cycle(); start_i = 0;
    in_valid_i = 1; res_ready_i = 1;
    g = 0;
    while (in_q.size() > 4 && g < 50) begin cycle(); g++; end
    chk("t1_acc_active", pe_acc_en_o, acc_pattern(3));
    rst_n = 0;
    #2;
    chk_zero("t1_async");
    model_reset();
    @(posedge clk);
    cyc++;
    #1;
    chk_zero("t1_edge");
    rst_n = 1;
    in_valid_i = 0;
    cycle();

    // T2: streaming job, then reuse start (T6), stalls, backpressure, busy start
    run_job("t2_stream", 1'b0, 0);
    chk("t2_latency_19", last_lat, 19);
    run_job("t6_reuse", 1'b1, 0);
`ifdef SEQ_WEIGHT_REUSE_EN
    chk("t6_latency_15", last_lat, 15);
`else
    chk("t6_latency_19", last_lat, 19);
`endif
    run_job("t3_in_stall", 1'b0, 1);
    run_job("t4_backpressure", 1'b0, 2);
    chk("t4_latency_22", last_lat, 22);
    run_job("t5_start_busy", 1'b0, 4);

    // Randomised jobs
    for (int j = 0; j < 8; j++) run_job("rand", 1'($urandom_range(0, 1)), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
